// File: rtl/fp_pkg.sv
// Shared single-precision types, constants and operand classification
// for the fp divider issue shell.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_INF_EXP = 8'hFF;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic special;
  } fp_flags_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

  // Denormals (exp == 0) classify as zero.
  function automatic fp_class_t fp_class(input logic [7:0] exp, input logic [22:0] mant);
    fp_class_t c;
    c.is_nan  = (exp == FP_INF_EXP) && (mant != 23'd0);
    c.is_inf  = (exp == FP_INF_EXP) && (mant == 23'd0);
    c.is_zero = (exp == 8'd0);
    return c;
  endfunction

endpackage

// File: rtl/fp_op_fifo.sv
// Generic synchronous FIFO with registered entry count; storage is not reset.
module fp_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 68
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata_c,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full_c,
  output logic                       empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == CNT_W'(0));
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign rdata_c = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fp_div_issue.sv
// Issue/writeback shell around a combinational fp32 divider: operand FIFO,
// local IEEE special-case resolution, tagged registered result.
module fp_div_issue
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  output logic [31:0]            div_a,
  output logic [31:0]            div_b,
  input  logic [31:0]            div_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [2:0]             res_flags,
  output logic [TAG_W-1:0]       res_tag,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned ENT_W = 64 + TAG_W;

  logic [TAG_W-1:0] tag_cnt;
  logic [ENT_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  fp32_t            ha;
  fp32_t            hb;
  fp_class_t        ca;
  fp_class_t        cb;
  logic             s;
  logic [31:0]      sel_data;
  fp_flags_t        sel_flags;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && (!res_valid || res_ready);

  fp_op_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   ({in_a, in_b, tag_cnt}),
    .rdata_c (head),
    .count   (occupancy),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  // Keep the divider inputs X-free when nothing is queued.
  assign div_a = fifo_empty ? 32'd0 : head[ENT_W-1 -: 32];
  assign div_b = fifo_empty ? 32'd0 : head[ENT_W-33 -: 32];

  // Special-operand resolution, highest priority first.
  always_comb begin
    ha        = fp32_t'(div_a);
    hb        = fp32_t'(div_b);
    ca        = fp_class(ha.exp, ha.mant);
    cb        = fp_class(hb.exp, hb.mant);
    s         = ha.sign ^ hb.sign;
    sel_data  = div_out;
    sel_flags = '0;
    if (ca.is_nan || cb.is_nan ||
        (ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
      sel_data  = FP_QNAN;
      sel_flags = '{invalid: 1'b1, div_by_zero: 1'b0, special: 1'b1};
    end else if (ca.is_inf) begin
      sel_data  = {s, FP_INF_EXP, 23'd0};
      sel_flags = '{invalid: 1'b0, div_by_zero: 1'b0, special: 1'b1};
    end else if (cb.is_zero) begin
      sel_data  = {s, FP_INF_EXP, 23'd0};
      sel_flags = '{invalid: 1'b0, div_by_zero: 1'b1, special: 1'b1};
    end else if (ca.is_zero || cb.is_inf) begin
      sel_data  = {s, 31'd0};
      sel_flags = '{invalid: 1'b0, div_by_zero: 1'b0, special: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt <= '0;
    end else if (push) begin
      tag_cnt <= tag_cnt + TAG_W'(1);
    end
  end

  // Result register: reload on pop, otherwise hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      res_tag   <= '0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_data  <= sel_data;
      res_flags <= sel_flags;
      res_tag   <= head[TAG_W-1:0];
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_div_issue.sv
// Bench for fp_div_issue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the issue shell.
module tb_fp_div_issue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_flags;
  logic [3:0]  res_tag;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [2:0]  f;
    logic [3:0]  t;
  } exp_t;

  exp_t     exp_q[$];
  int       m_occ;
  logic     m_rv;
  logic [3:0] m_tag;

  fp_div_issue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_out   (div_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .res_tag   (res_tag),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the fp_divider: exact for 6/3, an arbitrary mix otherwise.
  function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4040_0000) return 32'h4000_0000;
    return (a ^ {b[7:0], b[31:8]}) + 32'h0123_4567;
  endfunction

  assign div_out = fake_div(div_a, div_b);

  // IEEE special-case rules, returns {quotient, flags}.
  function automatic logic [34:0] ref_res(input logic [31:0] a, input logic [31:0] b);
    logic an, bn, ai, bi, az, bz, sg;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    sg = a[31] ^ b[31];
    if (an || bn)                    return {32'h7FC0_0000, 3'b101};
    if ((az && bz) || (ai && bi))    return {32'h7FC0_0000, 3'b101};
    if (ai)                          return {sg, 8'hFF, 23'd0, 3'b001};
    if (bz)                          return {sg, 8'hFF, 23'd0, 3'b011};
    if (az || bi)                    return {sg, 31'd0, 3'b001};
    return {fake_div(a, b), 3'b000};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
      4, 5:       return {r[31], 8'h00, (r[0] ? r[22:0] : 23'd0)};
      6:          return {r[31], 8'hFF, 23'd0};
      7:          return {r[31], 8'hFF, (r[22:0] | 23'd1)};
      default:    return r;
    endcase
  endfunction

  task automatic clear_model();
    exp_q.delete();
    m_occ = 0;
    m_rv  = 1'b0;
    m_tag = 4'd0;
  endtask

  // One clock: compare DUT against model state, advance model, step clock.
  task automatic tick();
    logic push_m, pop_m, deliver_m;
    int   hidx;
    exp_t e;
    total++;
    if (in_ready !== (m_occ != DEPTH)) begin
      bad++; $display("FAIL in_ready got=%b exp=%b", in_ready, (m_occ != DEPTH));
    end
    total++;
    if (occupancy !== 3'(m_occ)) begin
      bad++; $display("FAIL occupancy got=%0d exp=%0d", occupancy, m_occ);
    end
    total++;
    if (res_valid !== m_rv) begin
      bad++; $display("FAIL res_valid got=%b exp=%b", res_valid, m_rv);
    end
    if (m_rv && exp_q.size() > 0) begin
      total++;
      if (res_data !== exp_q[0].d || res_flags !== exp_q[0].f || res_tag !== exp_q[0].t) begin
        bad++;
        $display("FAIL result got=%h/%b/%0d exp=%h/%b/%0d", res_data, res_flags, res_tag,
                 exp_q[0].d, exp_q[0].f, exp_q[0].t);
      end
    end
    hidx = m_rv ? 1 : 0;
    total++;
    if (m_occ == 0) begin
      if (div_a !== 32'd0 || div_b !== 32'd0) begin
        bad++; $display("FAIL div_idle got=%h/%h exp=0/0", div_a, div_b);
      end
    end else if (exp_q.size() > hidx) begin
      if (div_a !== exp_q[hidx].a || div_b !== exp_q[hidx].b) begin
        bad++; $display("FAIL div_head got=%h/%h exp=%h/%h", div_a, div_b,
                        exp_q[hidx].a, exp_q[hidx].b);
      end
    end else begin
      bad++; $display("FAIL model_queue size=%0d occ=%0d", exp_q.size(), m_occ);
    end
    push_m    = in_valid && (m_occ != DEPTH);
    pop_m     = (m_occ > 0) && (!m_rv || res_ready);
    deliver_m = m_rv && res_ready;
    if (deliver_m && exp_q.size() > 0) void'(exp_q.pop_front());
    if (push_m) begin
      e.a = in_a;
      e.b = in_b;
      {e.d, e.f} = ref_res(in_a, in_b);
      e.t = m_tag;
      exp_q.push_back(e);
      m_tag = m_tag + 4'd1;
    end
    m_occ = m_occ + int'(push_m) - int'(pop_m);
    m_rv  = pop_m ? 1'b1 : (deliver_m ? 1'b0 : m_rv);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #3;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (res_valid !== 1'b0 || res_data !== 32'd0 || res_flags !== 3'd0 || res_tag !== 4'd0) begin
      bad++; $display("FAIL reset_result got=%b/%h/%b/%0d exp=0", res_valid, res_data, res_flags, res_tag);
    end
    total++;
    if (occupancy !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_fifo got occ=%0d rdy=%b exp occ=0 rdy=1", occupancy, in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    res_ready = 1'b1;
    in_valid  = 1'b1; in_a = 32'h40C0_0000; in_b = 32'h4040_0000;
    tick();
    in_valid = 1'b0;
    total++;
    if (res_valid !== 1'b0 || occupancy !== 3'd1) begin
      bad++; $display("FAIL basic_queued got v=%b occ=%0d exp v=0 occ=1", res_valid, occupancy);
    end
    tick();
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'h4000_0000 || res_flags !== 3'b000 || res_tag !== 4'd0) begin
      bad++; $display("FAIL basic_result got=%b/%h/%b/%0d exp=1/40000000/000/0",
                      res_valid, res_data, res_flags, res_tag);
    end
    tick();
  endtask

  task automatic test_specials();
    logic [31:0] ia [3];
    logic [31:0] ib [3];
    logic [31:0] ed [3];
    logic [2:0]  ef [3];
    ia = '{32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000};
    ib = '{32'h0000_0000, 32'h0000_0000, 32'h7F80_0000};
    ed = '{32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000};
    ef = '{3'b011, 3'b101, 3'b001};
    do_reset();
    res_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_valid = (j < 3);
      if (j < 3) begin in_a = ia[j]; in_b = ib[j]; end
      if (j >= 2) begin
        total++;
        if (res_valid !== 1'b1 || res_data !== ed[j-2] || res_flags !== ef[j-2] || res_tag !== 4'(j-2)) begin
          bad++; $display("FAIL special_%0d got=%b/%h/%b/%0d exp=1/%h/%b/%0d", j-2, res_valid,
                          res_data, res_flags, res_tag, ed[j-2], ef[j-2], j-2);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    res_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      in_a = rand_op(); in_b = rand_op();
      tick();
    end
    total++;
    if (in_ready !== 1'b0 || occupancy !== 3'd4 || res_valid !== 1'b1 || res_tag !== 4'd0) begin
      bad++; $display("FAIL bp_full got rdy=%b occ=%0d v=%b tag=%0d exp 0/4/1/0",
                      in_ready, occupancy, res_valid, res_tag);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      total++;
      if (res_valid !== 1'b1 || res_tag !== 4'(j)) begin
        bad++; $display("FAIL bp_drain_%0d got v=%b tag=%0d exp v=1 tag=%0d", j, res_valid, res_tag, j);
      end
      tick();
    end
    total++;
    if (res_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL bp_empty got v=%b occ=%0d exp 0/0", res_valid, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    res_ready = 1'b1;
    for (int j = 0; j < 19; j++) begin
      in_valid = (j < 17);
      in_a = rand_op(); in_b = rand_op();
      if (j >= 2) begin
        total++;
        if (res_valid !== 1'b1 || res_tag !== 4'((j - 2) % 16)) begin
          bad++; $display("FAIL b2b_%0d got v=%b tag=%0d exp v=1 tag=%0d", j - 2, res_valid,
                          res_tag, (j - 2) % 16);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    res_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_a = rand_op(); in_b = rand_op();
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (occupancy !== 3'd3 || res_valid !== 1'b1) begin
      bad++; $display("FAIL mid_setup got occ=%0d v=%b exp 3/1", occupancy, res_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (res_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL mid_reset got v=%b occ=%0d exp 0/0", res_valid, occupancy);
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    in_valid  = 1'b1; in_a = 32'h4040_0000; in_b = 32'h3F80_0000;
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (res_valid !== 1'b1 || res_tag !== 4'd0) begin
      bad++; $display("FAIL mid_tag got v=%b tag=%0d exp v=1 tag=0", res_valid, res_tag);
    end
    tick();
  endtask

  task automatic test_nan_priority();
    do_reset();
    res_ready = 1'b1;
    in_valid  = 1'b1; in_a = 32'h7FC0_0001; in_b = 32'h0000_0000;
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'h7FC0_0000 || res_flags !== 3'b101) begin
      bad++; $display("FAIL nan_prio got=%b/%h/%b exp=1/7fc00000/101", res_valid, res_data, res_flags);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int j = 0; j < 400; j++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      in_a = rand_op();
      in_b = rand_op();
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int j = 0; j < 8; j++) tick();
    total++;
    if (res_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL rand_drain got v=%b occ=%0d exp 0/0", res_valid, occupancy);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    res_ready = 1'b0;
    clear_model();
    test_reset();
    test_basic();
    test_specials();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_nan_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_div_issue.md
Name: fp_div_issue

Overview:
- Issue/writeback shell around the combinational single-precision fp_divider.
- Accepts operand pairs on a valid/ready interface, buffers them in a small FIFO, drives the FIFO head onto the divider and registers the result.
- Special IEEE-754 operands (NaN, Inf, zero) are resolved locally with exception flags, and each result is tagged with an issue sequence number.
- Sits between the operand source (register-read/dispatch) and the FPU result bus.

Parameters:
- DEPTH, 4, operand FIFO entries (power of 2, ≥2)
- TAG_W, 4, width of the sequence tag; tag counter wraps modulo 2^TAG_W

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  FIFO can accept
- in_a  input  32  dividend, IEEE-754 single
- in_b  input  32  divisor, IEEE-754 single
- div_a  output  32  to fp_divider a (FIFO head dividend; 0 when FIFO empty)
- div_b  output  32  to fp_divider b (FIFO head divisor; 0 when FIFO empty)
- div_out  input  32  from fp_divider out (combinational)
- res_valid  output  1  result register holds a result
- res_ready  input  1  consumer accepts result
- res_data  output  32  quotient
- res_flags  output  3  {invalid, div_by_zero, special_path}
- res_tag  output  TAG_W  sequence tag of this result
- occupancy  output  $clog2(DEPTH)+1  current FIFO entry count

Behaviour:
- Reset (async assert, sync release): FIFO pointers 0, occupancy 0, tag counter 0, res_valid 0, res_data 0, res_flags 0, res_tag 0, in_ready 1 after release.
- Push: in_valid && in_ready at edge → entry {in_a, in_b, tag_cnt} written; tag_cnt increments, wrapping 2^TAG_W−1 → 0.
- in_ready = (occupancy != DEPTH). No pass-through when full: push and pop in the same cycle while full is impossible, since push is blocked.
- Pop/capture: when occupancy > 0 and (!res_valid || res_ready), the head is popped at the edge and the result register is loaded; res_valid = 1.
- If res_valid && res_ready and the FIFO is empty, res_valid clears. res_data, res_flags and res_tag hold while res_valid && !res_ready.
- Simultaneous push and pop (not full): occupancy unchanged, both pointers advance, pointer wrap modulo DEPTH.
- Latency: an op accepted at edge k into an empty FIFO with a free result register → res_valid = 1 after edge k+1. Sustained throughput is 1 op/clk with res_ready held high.
- Result selection, evaluated in priority order on the head (sa/sb = sign bits, s = sa^sb):
  1. a or b NaN → 0x7FC00000, invalid=1, special=1
  2. 0/0 or Inf/Inf → 0x7FC00000, invalid=1, special=1
  3. a Inf → {s, 0x7F800000[30:0]}, special=1
  4. b zero (a finite nonzero) → {s, Inf}, div_by_zero=1, special=1
  5. a zero or b Inf → {s, 31'b0}, special=1
  6. otherwise → div_out, flags 000
- Denormal inputs are treated as zero for classification: exp == 0 means zero.
- Ordering: results leave strictly in acceptance order; res_tag equals the acceptance-order index modulo 2^TAG_W.
- Reset mid-operation: all queued ops and the held result are discarded, with no output pulse. The tag restarts at 0.
- Unused FIFO data is don't-care, but div_a/div_b are forced to 0 when the FIFO is empty so the divider sees no X.

Decomposition:
- Shared package fp_pkg:
  - typedef fp32_t (sign, exp[7:0], mant[22:0] packed struct)
  - constants FP_QNAN = 32'h7FC00000, FP_INF_EXP = 8'hFF
  - typedef fp_flags_t {invalid, div_by_zero, special}
  - function fp_class() returning {is_nan, is_inf, is_zero}
- One sub-module: fp_op_fifo, a generic DEPTH×(64+TAG_W) synchronous FIFO with count output. Special-case logic and the result register stay in fp_div_issue.

Test Plan:
- Basic op: push 0x40C00000 / 0x40400000 (6.0/3.0), res_ready=1 → next cycle res_valid=1, res_data=0x40000000, flags=000, tag=0.
- Specials: push 1.0/0 (0x3F800000/0x00000000), then 0/0, then −1.0/Inf (0xBF800000/0x7F800000) → results 0x7F800000 flags 011; 0x7FC00000 flags 101; 0x80000000 flags 001; tags 0, 1, 2.
- Backpressure: res_ready=0, push continuously → 5 ops accepted (1 in result register + 4 in FIFO), in_ready=0, occupancy=4. Then res_ready=1 → 5 results drain in order, one per clock.
- Throughput/tag wrap (TAG_W=4): 17 back-to-back ops with res_ready=1 → one result per cycle, tags 0..15 then 0, no bubbles.
- Reset mid-stream: 3 queued ops plus a held result, pulse rst_n low asynchronously mid-cycle → res_valid=0 and occupancy=0 immediately. The next op gets tag 0.
- NaN priority: a=0x7FC00001, b=0x00000000 → 0x7FC00000, flags 101, with div_by_zero not set.
